data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra cycles before the response is offered; range 0..15.
REQ-004 SHALL use one clock and asynchronous active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  initiator presents a request.
REQ-008 req_ready  output  1  responder accepts a request this cycle.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data.
REQ-012 req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  initiator takes the response.
REQ-015 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  request rejected: misaligned or out of range.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_CYCLES = 0.
REQ-018 SHALL drive req_ready = 1 only in IDLE; SHALL drive rsp_valid = 1 only in RESP.
REQ-019 SHALL accept a request on the rising edge where req_valid and req_ready are both 1; SHALL latch req_write, req_addr, req_wdata and req_be at that edge.
REQ-020 SHALL flag an error when req_addr[1:0] != 0 or when req_addr lies outside [BASE_ADDR, BASE_ADDR + 4*DEPTH - 1]; the address is compared as unsigned 32-bit, and the upper-bound computation does not wrap.
REQ-021 SHALL commit a valid store at the acceptance edge, updating only the bytes enabled by req_be; be = 4'b0000 is a no-op with a normal response.
REQ-022 SHALL capture the full word for a valid load at the acceptance edge, ignoring req_be.
REQ-023 SHALL use word index (req_addr - BASE_ADDR) >> 2.
REQ-024 SHALL load a down-counter with WAIT_CYCLES on acceptance, decrement it once per WAIT cycle, and enter RESP on the edge where it reaches 0.
REQ-025 SHALL assert rsp_valid first in the cycle following edge k + WAIT_CYCLES, where k is the acceptance edge.
REQ-026 SHALL hold rsp_valid, rsp_rdata and rsp_err stable until the edge where rsp_valid and rsp_ready are both 1, then return to IDLE.
REQ-027 SHALL make req_ready = 1 in the cycle after the response handshake; there is no same-cycle turnaround.
REQ-028 SHALL leave memory unchanged on an erroring request; rsp_rdata = 0 and rsp_err = 1 for it.
REQ-029 SHALL ignore req_* while not in IDLE.
REQ-030 SHALL tolerate rsp_ready held high continuously, and rsp_ready asserted before rsp_valid.

Reset
REQ-031 SHALL force, on assertion of rst, state = IDLE, counter = 0, req_ready = 0 while rst is high, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0.
REQ-032 SHALL abort any pending response on reset mid-operation; a store already committed at acceptance remains in memory.
REQ-033 SHALL NOT clear memory contents on reset; contents are undefined until written.
REQ-034 SHALL drive req_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-035 SHALL place the FSM state encoding (IDLE, WAIT, RESP) and the default BASE_ADDR in the shared package mem_pkg.
REQ-036 SHALL place the storage array in sub-module sram_1rw: synchronous byte-enabled write, combinational read, DEPTH words.
REQ-037 SHALL keep the range/alignment check, counter and FSM in data_mem_responder.

Verification
REQ-038 Store then load (defaults): store addr 0x10010008, wdata 0xDEADBEEF, be 4'hF, rsp_ready = 1; then load 0x10010008 -> rsp_valid in the cycle after edge k + 2; rsp_rdata = 0xDEADBEEF; rsp_err = 0.
REQ-039 Byte enables: memory word at 0x10010008 = 0xDEADBEEF; store wdata 0x11223344 with be 4'b0101; load 0x10010008 -> 0xDE22BE44.
REQ-040 Errors: load 0x1001000A -> rsp_err = 1, rdata = 0; store to 0x10010400 -> rsp_err = 1, memory unchanged; load 0x1000FFFC -> rsp_err = 1.
REQ-041 Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid rises -> rsp_valid and rsp_rdata stable throughout, req_ready = 0 throughout; req_ready rises the cycle after the handshake.
REQ-042 Reset mid-operation: assert rst during WAIT of a store of 0x0000CAFE to 0x10010010 -> rsp_valid = 0 immediately, req_ready = 1 one cycle after release; a later load of 0x10010010 returns 0x0000CAFE.
REQ-043 WAIT_CYCLES = 0: a load accepted at edge k -> rsp_valid in the cycle after edge k; back-to-back requests complete one per 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder slice.
//   state_t           : responder FSM encoding (IDLE, WAIT, RESP)
//   DEFAULT_BASE_ADDR : byte address of word 0 unless overridden
//   BYTE_LANES        : byte lanes per 32-bit word (width of the byte enables)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
  localparam int          BYTE_LANES        = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a memory initiator and the data memory responder.
//
// Handshake rule (both channels): a transfer happens on the rising clk edge where
// valid and ready are both 1. Once the sender raises valid it holds valid and its
// payload stable until that edge. ready may be high before valid rises.
//
// Signals:
//   req_valid, req_write, req_addr, req_wdata, req_be : request from initiator
//   req_ready                                         : responder can accept
//   rsp_valid, rsp_rdata, rsp_err                     : response from responder
//   rsp_ready                                         : initiator takes response
// Modports: master = initiator side, slave = responder side.
interface data_mem_responder_if;
  import mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [BYTE_LANES-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_1rw.sv
// Single-port word memory: synchronous byte-enabled write, combinational read.
// Contents are never reset.
//   clk   : write clock
//   we    : write strobe, sampled on rising clk
//   addr  : word index, shared by read and write
//   wdata : write data
//   be    : byte enables; bit i writes wdata[8i+7:8i]
//   rdata : word at addr (combinational)
module sram_1rw
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  input  logic [BYTE_LANES-1:0] be,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, performs it at the
// acceptance edge, then offers the response WAIT_CYCLES cycles later.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset (memory contents are kept)
//   bus       : request/response bus, slave side
//   state_dbg : current FSM state, for observation only
// Parameters: BASE_ADDR (byte address of word 0), DEPTH (words, power of two),
// WAIT_CYCLES (0..15 extra cycles before the response).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output state_t               state_dbg
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Window size in bytes, kept 33 bits wide so the upper bound never wraps.
  localparam logic [32:0] SPAN      = 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        ready_fsm;
  logic        accept;
  logic [32:0] offset;
  logic        addr_err;
  logic [AW-1:0] word_idx;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] rdata_q;
  logic        err_q;

  // Unsigned distance from BASE_ADDR; bit 32 is the borrow for addresses below it.
  assign offset   = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || offset[32] || (offset >= SPAN);
  assign word_idx = offset[AW+1:2];

  assign bus.req_ready = ready_fsm && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign mem_we        = accept && bus.req_write && !addr_err;

  sram_1rw #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (bus.req_wdata),
    .be    (bus.req_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // The response payload is fixed at acceptance and held until the handshake.
      if (accept) begin
        err_q   <= addr_err;
        rdata_q <= (!bus.req_write && !addr_err) ? mem_rdata : 32'h0;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ready_fsm     = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        ready_fsm = 1'b1;
        if (bus.req_valid) begin
          cnt_nx   = WAIT_INIT;
          state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Leave on the edge where the counter reaches zero.
        if (cnt <= 4'd1) begin
          cnt_nx   = 4'd0;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 256;
  localparam int          W     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_responder_if bus();
  data_mem_responder_if bus0();
  state_t dut_state, dut0_state;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(dut_state)
  );

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(dut0_state)
  );

  // ---------------- check bookkeeping ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s: event did not occur within its bound (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Memory as a sparse word map; each accepted request's response is queued.
  logic [31:0] mem_m [int];
  logic [32:0] exp_q [$];   // {err, rdata}
  bit          m_busy = 0;
  int          m_due  = 0;

  function automatic logic [32:0] model_access(input bit wr, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] be);
    longint a, lo, hi;
    int     idx;
    logic [31:0] w;
    a  = longint'({32'h0, addr});
    lo = longint'({32'h0, BASE});
    hi = lo + 4 * DEPTH;
    if ((addr % 4) != 0 || a < lo || a >= hi) return {1'b1, 32'h0};
    idx = int'((a - lo) / 4);
    w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    if (!wr) return {1'b0, w};
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
    mem_m[idx] = w;
    return {1'b0, 32'h0};
  endfunction

  // Every cycle: outputs against the model, then predict the coming edge.
  always @(negedge clk) begin : compare
    logic v;
    if (rst) begin
      m_busy = 0;
      exp_q.delete();
      chkb("rst_req_ready", bus.req_ready, 1'b0);
      chkb("rst_rsp_valid", bus.rsp_valid, 1'b0);
    end else begin
      v = m_busy && (cyc >= m_due);
      chkb("req_ready", bus.req_ready, !m_busy);
      chkb("rsp_valid", bus.rsp_valid, v);
      if (v) begin
        if (exp_q.size() == 0) fail_now("exp_q_empty");
        else begin
          chk("rsp_rdata", bus.rsp_rdata, exp_q[0][31:0]);
          chkb("rsp_err", bus.rsp_err, exp_q[0][32]);
        end
      end
      if (!m_busy && bus.req_valid) begin
        exp_q.push_back(model_access(bus.req_write, bus.req_addr, bus.req_wdata, bus.req_be));
        m_busy = 1;
        m_due  = cyc + 1 + W;
      end else if (v && bus.rsp_ready) begin
        void'(exp_q.pop_front());
        m_busy = 0;
      end
    end
  end

  // ---------------- driver tasks (entered at posedge + #1) ----------------
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int acc_cyc);
    bit ok = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1;
    end
    if (!ok) fail_now("req_timeout");
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [31:0] rd, output logic er, output int vc);
    bit seen = 0;
    rd = 32'h0;
    er = 1'b0;
    vc = 0;
    bus.rsp_ready = (hold == 0);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    if (!seen) begin
      fail_now("rsp_timeout");
      @(posedge clk);
      #1;
      return;
    end
    vc = cyc;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("bp_rdata_stable", bus.rsp_rdata, rd);
      chkb("bp_valid_held", bus.rsp_valid, 1'b1);
      chkb("bp_req_ready_low", bus.req_ready, 1'b0);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    int ac, vc;
    do_req(wr, addr, wdata, be, ac);
    get_rsp(0, rd, er, vc);
    lat = vc - ac;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, ac, vc;

    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_be = 0; bus.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_be = 0; bus0.rsp_ready = 0;
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chkb("rst_err", bus.rsp_err, 1'b0);
    chk("rst_state", 32'(dut_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chkb("post_rst_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;

    // Store then load, latency of two wait cycles
    txn(1, 32'h1001_0008, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chkb("st_err", er, 1'b0);
    chk("st_rdata", rd, 32'h0);
    chk("st_lat", 32'(lat), 32'd2);
    txn(0, 32'h1001_0008, 32'h0, 4'h0, rd, er, lat);
    chk("ld_rdata", rd, 32'hDEAD_BEEF);
    chkb("ld_err", er, 1'b0);
    chk("ld_lat", 32'(lat), 32'd2);

    // Byte enables
    txn(1, 32'h1001_0008, 32'h1122_3344, 4'b0101, rd, er, lat);
    txn(0, 32'h1001_0008, 32'h0, 4'hF, rd, er, lat);
    chk("be_merge", rd, 32'hDE22_BE44);

    // Empty byte enable: normal response, no change
    txn(1, 32'h1001_0008, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chkb("be0_err", er, 1'b0);
    txn(0, 32'h1001_0008, 32'h0, 4'h0, rd, er, lat);
    chk("be0_unchanged", rd, 32'hDE22_BE44);

    // Errors and window edges
    txn(0, 32'h1001_000A, 32'h0, 4'hF, rd, er, lat);
    chkb("misalign_err", er, 1'b1);
    chk("misalign_rdata", rd, 32'h0);
    txn(1, 32'h1001_0000, 32'h0102_0304, 4'hF, rd, er, lat);
    txn(1, 32'h1001_03FC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    chkb("top_word_err", er, 1'b0);
    txn(1, 32'h1001_0400, 32'h1111_1111, 4'hF, rd, er, lat);
    chkb("above_err", er, 1'b1);
    txn(0, 32'h1001_0000, 32'h0, 4'h0, rd, er, lat);
    chk("word0_unchanged", rd, 32'h0102_0304);
    txn(0, 32'h1001_03FC, 32'h0, 4'h0, rd, er, lat);
    chk("top_word_rdata", rd, 32'hCAFE_F00D);
    txn(0, 32'h1000_FFFC, 32'h0, 4'h0, rd, er, lat);
    chkb("below_err", er, 1'b1);

    // Backpressure with an ignored request presented while busy
    do_req(0, 32'h1001_0008, 32'h0, 4'h0, ac);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h1001_0008;
    bus.req_wdata = 32'hFFFF_FFFF; bus.req_be = 4'hF;
    get_rsp(5, rd, er, vc);
    chk("bp_rdata", rd, 32'hDE22_BE44);
    @(negedge clk);
    chkb("bp_ready_after", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    txn(0, 32'h1001_0008, 32'h0, 4'h0, rd, er, lat);
    chk("busy_req_ignored", rd, 32'hDE22_BE44);

    // Reset during WAIT of a store
    do_req(1, 32'h1001_0010, 32'h0000_CAFE, 4'hF, ac);
    rst = 1'b1;
    #1;
    chkb("midrst_valid", bus.rsp_valid, 1'b0);
    chk("midrst_state", 32'(dut_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chkb("midrst_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    txn(0, 32'h1001_0010, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_kept", rd, 32'h0000_CAFE);

    // Zero wait cycles: back-to-back stores complete one per two cycles
    bus0.rsp_ready = 1'b1;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h1001_0020;
    bus0.req_wdata = 32'hA5A5_A5A5; bus0.req_be = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chkb("w0_ready", bus0.req_ready, (i % 2) == 0);
      chkb("w0_valid", bus0.rsp_valid, (i % 2) == 1);
      if ((i % 2) == 1) begin
        chk("w0_st_rdata", bus0.rsp_rdata, 32'h0);
        chkb("w0_st_err", bus0.rsp_err, 1'b0);
      end
    end
    @(posedge clk); #1;
    bus0.req_write = 1'b0;
    @(negedge clk);
    chkb("w0_ld_ready", bus0.req_ready, 1'b1);
    @(negedge clk);
    chkb("w0_ld_valid", bus0.rsp_valid, 1'b1);
    chk("w0_ld_rdata", bus0.rsp_rdata, 32'hA5A5_A5A5);
    chkb("w0_ld_err", bus0.rsp_err, 1'b0);
    @(posedge clk); #1;
    bus0.req_addr = 32'h1001_0021;
    @(negedge clk);
    @(negedge clk);
    chkb("w0_mis_valid", bus0.rsp_valid, 1'b1);
    chkb("w0_mis_err", bus0.rsp_err, 1'b1);
    chk("w0_mis_rdata", bus0.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
